// File: rtl/ym3438_write_sched.sv
// ym3438_write_sched: holds one pending CPU register write and commits it in the owning operator slot.
// Optional sticky overwrite flag on wr_ovr when YM_WRITE_SCHED_OVR_EN is defined.
module ym3438_write_sched #(
    parameter int BUSY_SLOTS = 32
) (
    input  logic       MCLK,
    input  logic       reset_n,
    input  logic       slot_en,
    input  logic       slot_sync,
    input  logic       wr_en,
    input  logic       wr_a0,
    input  logic       wr_port,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       reg_we,
    output logic [8:0] reg_addr,
    output logic [7:0] reg_data,
    output logic [4:0] reg_slot,
    output logic [4:0] slot_cnt,
    output logic       wr_ovr
);
    localparam int BW = $clog2(BUSY_SLOTS + 1);
    typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;
    state_t          state_q, state_d;
    logic [BW-1:0]   bc_q, bc_d;
    logic [4:0]      slot_q, pt_q, rs_q, base, tgt;
    logic [8:0]      lat_q, pa_q, ra_q;
    logic [7:0]      pd_q, rd_q, a;
    logic            pg_q, we_q, p, aw, dw, v_glob, v_op, v_ch, valid, commit;
    logic [2:0]      ch;
    always_comb begin
        aw      = wr_en & wr_a0;
        dw      = wr_en & ~wr_a0;
        a       = lat_q[7:0];
        p       = lat_q[8];
        v_glob  = !p && a >= 8'h21 && a <= 8'h2F;
        v_op    = a >= 8'h30 && a <= 8'h9F && a[1:0] != 2'd3;
        v_ch    = a >= 8'hA0 && a <= 8'hB6 && a[1:0] != 2'd3;
        valid   = v_glob | v_op | v_ch;
        ch      = {1'b0, a[1:0]} + (p ? 3'd3 : 3'd0);
        base    = a[3:2] == 2'd0 ? 5'd6 : a[3:2] == 2'd1 ? 5'd12 : a[3:2] == 2'd2 ? 5'd18 : 5'd0;
        tgt     = v_ch ? {2'b00, ch} : base + {2'b00, ch};
        // the old entry commits even if a new data write lands in the same cycle
        commit  = state_q == PEND && slot_en && (pg_q || slot_q == pt_q);
        bc_d    = (commit || (dw && !valid)) ? BW'(BUSY_SLOTS) :
                  (slot_en && bc_q != '0) ? bc_q - 1'b1 : bc_q;
        state_d = dw ? (valid ? PEND : HOLD) :
                  commit ? HOLD :
                  (state_q == HOLD && bc_d == '0) ? IDLE : state_q;
    end
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            bc_q    <= '0;
            slot_q  <= '0;
            lat_q   <= '0;
            pa_q    <= '0;
            pd_q    <= '0;
            pt_q    <= '0;
            pg_q    <= 1'b0;
            we_q    <= 1'b0;
            ra_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            we_q    <= commit;
            if (slot_en) slot_q <= (slot_sync || slot_q == 5'd23) ? 5'd0 : slot_q + 5'd1;
            if (aw) lat_q <= {wr_port, wr_data};
            if (dw) begin
                pa_q <= lat_q;
                pd_q <= wr_data;
                pt_q <= tgt;
                pg_q <= v_glob;
            end
            if (commit) begin
                ra_q <= pa_q;
                rd_q <= pd_q;
                rs_q <= slot_q;
            end
        end
    end
`ifdef YM_WRITE_SCHED_OVR_EN
    logic ovr_q;
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) ovr_q <= 1'b0;
        else ovr_q <= (dw && state_q == PEND && !commit) || (ovr_q && !aw);
    end
    assign wr_ovr = ovr_q;
`else
    assign wr_ovr = 1'b0;
`endif
    assign busy     = state_q == PEND || bc_q != '0;
    assign reg_we   = we_q;
    assign reg_addr = ra_q;
    assign reg_data = rd_q;
    assign reg_slot = rs_q;
    assign slot_cnt = slot_q;
endmodule

// File: tb/tb_ym3438_write_sched.sv
// tb_ym3438_write_sched: scoreboard bench; expected commits queued at stimulus, matched on reg_we.
module tb_ym3438_write_sched;
    logic       MCLK = 1'b0, reset_n = 1'b0, slot_en = 1'b0, slot_sync = 1'b0;
    logic       wr_en = 1'b0, wr_a0 = 1'b0, wr_port = 1'b0;
    logic [7:0] wr_data = '0;
    logic       busy, reg_we, wr_ovr;
    logic [8:0] reg_addr;
    logic [7:0] reg_data;
    logic [4:0] reg_slot, slot_cnt;
    int         n_chk = 0, n_err = 0;
    logic [4:0] ms = '0;
    logic [21:0] sb[$];
    ym3438_write_sched #(.BUSY_SLOTS(32)) dut (
        .MCLK(MCLK), .reset_n(reset_n), .slot_en(slot_en), .slot_sync(slot_sync),
        .wr_en(wr_en), .wr_a0(wr_a0), .wr_port(wr_port), .wr_data(wr_data),
        .busy(busy), .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
        .reg_slot(reg_slot), .slot_cnt(slot_cnt), .wr_ovr(wr_ovr)
    );
    always #5 MCLK = ~MCLK;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    always @(negedge MCLK) begin
        if (reg_we === 1'b1) begin
            if (sb.size() == 0) check("unexp_we", 1, 0);
            else begin
                logic [21:0] e;
                e = sb.pop_front();
                check("we_addr", reg_addr, e[21:13]);
                check("we_data", reg_data, e[12:5]);
                check("we_slot", reg_slot, e[4:0]);
            end
        end
    end
    task automatic slot_tick(input logic sync);
        slot_en = 1'b1; slot_sync = sync;
        @(posedge MCLK); #1;
        slot_en = 1'b0; slot_sync = 1'b0;
        ms = (sync || ms == 5'd23) ? 5'd0 : ms + 5'd1;
        repeat (2) @(posedge MCLK);
        #1;
    endtask
    task automatic wr(input logic a0, input logic p, input logic [7:0] d);
        wr_en = 1'b1; wr_a0 = a0; wr_port = p; wr_data = d;
        @(posedge MCLK); #1;
        wr_en = 1'b0;
    endtask
    task automatic wr_tick(input logic [7:0] d);
        wr_en = 1'b1; wr_a0 = 1'b0; wr_data = d; slot_en = 1'b1;
        @(posedge MCLK); #1;
        wr_en = 1'b0; slot_en = 1'b0;
        ms = ms == 5'd23 ? 5'd0 : ms + 5'd1;
        repeat (2) @(posedge MCLK);
        #1;
    endtask
    task automatic drain(input string tag);
        for (int i = 0; i < 30 && sb.size() != 0; i++) slot_tick(1'b0);
        check(tag, sb.size(), 0);
    endtask
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 80 && busy; i++) slot_tick(1'b0);
        check(tag, busy, 0);
    endtask
    initial begin
        repeat (3) @(posedge MCLK);
        #1;
        check("rst_busy", busy, 0);
        check("rst_we", reg_we, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_data", reg_data, 0);
        check("rst_slot", reg_slot, 0);
        check("rst_cnt", slot_cnt, 0);
        check("rst_ovr", wr_ovr, 0);
        reset_n = 1'b1;
        @(posedge MCLK); #1;
        repeat (24) slot_tick(1'b0);
        check("wrap_cnt", slot_cnt, 0);
        repeat (6) slot_tick(1'b0);
        check("cnt_30", slot_cnt, 6);
        check("idle_busy", busy, 0);
        // global register commits on the next tick in whatever slot is current
        wr(1'b1, 1'b0, 8'h28);
        check("aw_no_busy", busy, 0);
        wr(1'b0, 1'b0, 8'hF1);
        check("glob_busy_rise", busy, 1);
        sb.push_back({9'h028, 8'hF1, ms});
        slot_tick(1'b0);
        check("glob_lat", sb.size(), 0);
        repeat (31) slot_tick(1'b0);
        check("busy_31", busy, 1);
        slot_tick(1'b0);
        check("busy_32", busy, 0);
        wr(1'b1, 1'b1, 8'h36);
        wr(1'b0, 1'b0, 8'h55);
        sb.push_back({9'h136, 8'h55, 5'd17});
        drain("p1_drain");
        wait_idle("p1_idle");
        wr(1'b1, 1'b0, 8'h42);
        wr(1'b0, 1'b0, 8'h10);
        check("ovr_first", wr_ovr, 0);
        wr(1'b0, 1'b0, 8'h20);
        sb.push_back({9'h042, 8'h20, 5'd8});
`ifdef YM_WRITE_SCHED_OVR_EN
        check("ovr_set", wr_ovr, 1);
`else
        check("ovr_set", wr_ovr, 0);
`endif
        drain("ovr_drain");
        check("ovr_sticky_busy", busy, 1);
        wr(1'b1, 1'b0, 8'h33);
        check("ovr_clear", wr_ovr, 0);
        wait_idle("ovr_idle");
        wr(1'b0, 1'b0, 8'hAA);
        check("inv_busy", busy, 1);
        repeat (31) slot_tick(1'b0);
        check("inv_busy_31", busy, 1);
        slot_tick(1'b0);
        check("inv_busy_32", busy, 0);
        // old entry commits while the simultaneous write becomes the new pending one
        wr(1'b1, 1'b0, 8'h2B);
        wr(1'b0, 1'b0, 8'h11);
        sb.push_back({9'h02B, 8'h11, ms});
        sb.push_back({9'h02B, 8'h22, ms + 5'd1});
        wr_tick(8'h22);
        check("same_cyc_pend", busy, 1);
        slot_tick(1'b0);
        check("same_cyc_drain", sb.size(), 0);
        wait_idle("same_cyc_idle");
        repeat (5) slot_tick(1'b0);
        slot_tick(1'b1);
        check("sync_cnt", slot_cnt, 0);
        wr(1'b1, 1'b0, 8'h30);
        wr(1'b0, 1'b0, 8'h99);
        slot_tick(1'b0);
        slot_tick(1'b0);
        check("pend_before_rst", busy, 1);
        reset_n = 1'b0;
        #2;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cnt", slot_cnt, 0);
        @(posedge MCLK); #1;
        reset_n = 1'b1;
        ms = '0;
        repeat (30) slot_tick(1'b0);
        check("rst_no_commit_addr", reg_addr, 0);
        check("rst_no_commit_busy", busy, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
